// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator family.
// Holds the per-axis segment state encoding, the default 640x480@60
// timing constants, and small sizing helpers used by the axis counter
// and the top-level coordinate outputs.
package vga_pkg;

    // Axis segment order is FP -> SYNC -> BP -> VIS -> FP.
    typedef enum logic [1:0] {
        ST_FP   = 2'd0,
        ST_SYNC = 2'd1,
        ST_BP   = 2'd2,
        ST_VIS  = 2'd3
    } axis_state_t;

    // Default 640x480@60 timing (25.175 MHz pixel clock).
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic axis_state_t axis_next(axis_state_t s);
        case (s)
            ST_FP:   return ST_SYNC;
            ST_SYNC: return ST_BP;
            ST_BP:   return ST_VIS;
            default: return ST_FP;
        endcase
    endfunction

    // Width able to hold 0..len-1; never narrower than one bit.
    function automatic int vis_w(int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Segment counter width: sized to the longest segment on the axis.
    function automatic int seg_cnt_w(int fp, int sync, int bp, int vis);
        int m;
        m = fp;
        if (sync > m) m = sync;
        if (bp > m)   m = bp;
        if (vis > m)  m = vis;
        return vis_w(m);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle between the timing generator and the pixel pipeline.
//   clk_en      : pixel advance enable (driven by the integrator)
//   h_sync      : horizontal sync at configured polarity
//   v_sync      : vertical sync at configured polarity
//   h_active    : horizontal visible region
//   v_active    : vertical visible region
//   active      : h_active & v_active
//   x, y        : pixel column/row inside the visible region, else 0
//   line_start  : first pixel of every line
//   frame_start : first pixel of every frame
// master = timing generator, slave = pixel pipeline.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int XW = vis_w(DEF_H_VIS),
    parameter int YW = vis_w(DEF_V_VIS)
);
    logic          clk_en;
    logic          h_sync;
    logic          v_sync;
    logic          h_active;
    logic          v_active;
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  clk_en,
        output h_sync, v_sync, h_active, v_active, active,
        output x, y, line_start, frame_start
    );

    modport slave (
        output clk_en,
        input  h_sync, v_sync, h_active, v_active, active,
        input  x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: a four-segment FSM (FP -> SYNC -> BP -> VIS -> FP)
// with a shared segment counter. Each step advances the counter; on the
// last count of a segment the counter clears and the state moves on.
// Ports:
//   clk     : pixel-domain clock
//   reset   : asynchronous, active-low reset (state FP, count 0)
//   step_i  : advance this axis by one unit (pixel or line)
//   state_o : current segment
//   count_o : position inside the current segment
//   last_o  : step on the final unit of the visible segment
module vga_timing_axis
    import vga_pkg::*;
#(
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP,
    parameter int VIS  = DEF_H_VIS,
    localparam int CW  = seg_cnt_w(FP, SYNC, BP, VIS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_i,
    output axis_state_t   state_o,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    if (FP < 1 || SYNC < 1 || BP < 1 || VIS < 1) begin : g_bad_cfg
        $fatal(1, "vga_timing_axis: every segment length must be >= 1");
    end

    axis_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [CW-1:0] seg_end(axis_state_t s);
        case (s)
            ST_FP:   return CW'(FP - 1);
            ST_SYNC: return CW'(SYNC - 1);
            ST_BP:   return CW'(BP - 1);
            default: return CW'(VIS - 1);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (step_i) begin
            // A width-1 segment hits its end on count 0, so it lasts one step.
            if (count_q == seg_end(state_q)) begin
                count_d = '0;
                state_d = axis_next(state_q);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state_o = state_q;
    assign count_o = count_q;
    assign last_o  = step_i && (state_q == ST_VIS) && (count_q == CW'(VIS - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. A horizontal axis steps on every
// enabled pixel; a vertical axis steps on the last visible pixel of each
// line. All outputs are combinational decodes of the two axis registers,
// so they change only on enabled clock edges (or on reset).
// Ports:
//   clk   : pixel-domain clock
//   reset : asynchronous, active-low reset
//   vif   : timing bundle (clk_en in; sync, active, x/y, strobes out)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS      = DEF_H_VIS,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VIS      = DEF_V_VIS,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int XW         = vis_w(H_VIS),
    parameter int YW         = vis_w(V_VIS)
) (
    input logic              clk,
    input logic              reset,
    vga_timing_gen_if.master vif
);

    localparam int HCW = seg_cnt_w(H_FP, H_SYNC, H_BP, H_VIS);
    localparam int VCW = seg_cnt_w(V_FP, V_SYNC, V_BP, V_VIS);

    axis_state_t    h_state, v_state;
    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_last;
    logic           v_last_unused;

    vga_timing_axis #(
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .VIS  (H_VIS)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .step_i  (vif.clk_en),
        .state_o (h_state),
        .count_o (h_cnt),
        .last_o  (h_last)
    );

    vga_timing_axis #(
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .VIS  (V_VIS)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .step_i  (h_last),
        .state_o (v_state),
        .count_o (v_cnt),
        .last_o  (v_last_unused)
    );

    logic h_vis, v_vis, line_first;

    assign h_vis      = (h_state == ST_VIS);
    assign v_vis      = (v_state == ST_VIS);
    assign line_first = (h_state == ST_FP) && (h_cnt == '0);

    assign vif.h_sync      = (h_state == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
    assign vif.v_sync      = (v_state == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
    assign vif.h_active    = h_vis;
    assign vif.v_active    = v_vis;
    assign vif.active      = h_vis && v_vis;
    // Counters are sized to the longest segment; in VIS they never exceed VIS-1.
    assign vif.x           = h_vis ? XW'(h_cnt) : '0;
    assign vif.y           = v_vis ? YW'(v_cnt) : '0;
    // Strobes are qualified by clk_en so they mark exactly one enabled cycle.
    assign vif.line_start  = vif.clk_en && line_first;
    assign vif.frame_start = vif.clk_en && line_first &&
                             (v_state == ST_FP) && (v_cnt == '0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing generator.
- Per-axis porch, sync and visible widths, sync polarity and a pixel clock-enable are all configurable.
- Adds pixel x/y coordinates and line/frame start strobes.
- Sits between the pixel clock domain and the framebuffer-less pixel pipeline, which consumes x/y/active and drives RGB.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, h_sync asserted level (0 = active-low)
V_SYNC_POL, 0, v_sync asserted level
XW, $clog2(H_VIS), x width (derived)
YW, $clog2(V_VIS), y width (derived)

Ports:
clk  in  1  pixel-domain clock
reset  in  1  asynchronous, active-low reset
clk_en  in  1  pixel advance enable; all state holds when 0
h_sync  out  1  horizontal sync at configured polarity
v_sync  out  1  vertical sync at configured polarity
h_active  out  1  horizontal visible region
v_active  out  1  vertical visible region
active  out  1  h_active & v_active
x  out  XW  pixel column during h_active, else 0
y  out  YW  line row during v_active, else 0
line_start  out  1  first pixel of every line (qualified by clk_en)
frame_start  out  1  first pixel of every frame (qualified by clk_en)

Behaviour:
- Constraints: all width parameters >= 1. Violations are fatal at elaboration.
- Each axis runs a 4-state FSM with sequence FP -> SYNC -> BP -> VIS -> FP, plus a segment counter sized to the largest segment on that axis.
- Horizontal axis, on each clk_en=1 edge:
  - counter increments.
  - At counter == segment_len-1: counter clears and state advances. VIS wraps to FP.
- Vertical axis advances only on the clk_en=1 edge where h_state==VIS and h counter==H_VIS-1 (last pixel of line). It uses the same counter/advance rule.
- clk_en=0: no state or counter changes; outputs stay stable.
- Outputs are combinational decodes of registered state, with zero latency from state:
  - h_sync = (h_state==SYNC) ? H_SYNC_POL : ~H_SYNC_POL. v_sync likewise.
  - x = h counter when h_state==VIS, else 0. y = v counter when v_state==VIS, else 0.
  - line_start = clk_en & h_state==FP & h_cnt==0.
  - frame_start = line_start & v_state==FP & v_cnt==0.
- Periods: line = H_FP+H_SYNC+H_BP+H_VIS enabled cycles; frame = line * (V_FP+V_SYNC+V_BP+V_VIS). Defaults give 800 and 420000.
- Reset (async assert, any time including mid-line): both states FP, both counters 0.
  - Outputs immediately read: h_sync/v_sync inactive, active 0, x=y=0.
  - On the first clk_en=1 cycle after deassert, line_start=1 and frame_start=1.
- Reset deassertion is synchronised by the integrator. This block assumes clean release.
- Width-1 segments are legal: a state lasts exactly one enabled cycle. No state is skipped.

Decomposition:
- Shared package vga_pkg holds:
  - the axis-state localparams (ST_FP=0, ST_SYNC=1, ST_BP=2, ST_VIS=3) and a 2-bit state typedef;
  - default 640x480@60 timing constants, reused by later modes.
- One natural sub-module, vga_timing_axis, instantiated twice:
  - parameters: FP/SYNC/BP/VIS lengths;
  - inputs: clk, reset, step;
  - outputs: state, count, last (step & state==VIS & count==VIS-1).
- Horizontal instance step = clk_en. Vertical instance step = horizontal last.

Test Plan:
- Reset release, defaults, clk_en=1 -> first cycle line_start=1, frame_start=1, active=0. h_sync falls at enabled cycle 16 and stays low 96 cycles. h_active rises at cycle 160 with x=0, reaches x=639 at cycle 799, and line_start repeats at cycle 800.
- Full default frame -> v_sync low for lines 10-11. First active line is line 45 with y=0; y=479 on line 524. frame_start period is exactly 420000 cycles. Count of active=1 cycles = 307200.
- clk_en toggling 1,0,1,0 -> line_start period 1600 clk cycles. All outputs constant across every clk_en=0 cycle.
- Small config (H 2/1/1/1 VIS/FP/SYNC/BP, V 2/1/1/1), H_SYNC_POL=1 -> line 5 cycles, frame 25 cycles, h_sync high exactly 1 cycle per line. Every state visited, including width-1 segments.
- Async reset asserted mid-line (x=300, y=200) between clock edges -> outputs return to reset values before the next edge. After release, frame_start=1 on the next enabled cycle.
